// File: rtl/spike_activity_gate.sv
// spike_activity_gate
//   Watches P_CHANNELS spike lines and opens an activity window of P_WINDOW
//   i_win_tick pulses once P_SPIKE_NOM spike events have accumulated. Renewed
//   activity retriggers the window. A watchdog discards a stale partial count
//   after P_IDLE quiet cycles.
//   Optional feature macro: SPIKE_POPCOUNT_EN. When it is defined, each cycle
//   adds the number of set spike lines. When it is undefined, each cycle adds
//   1 if any spike line is set.
//   Handshake: there is none. i_spike_in and i_win_tick are sampled on every
//   rising i_clk edge. All outputs are registered and are valid every cycle.
module spike_activity_gate #(
  parameter int P_CHANNELS  = 4,
  parameter int P_SPIKE_NOM = 4,
  parameter int P_WINDOW    = 4,
  parameter int P_IDLE      = 244,
  localparam int CW = $clog2(P_SPIKE_NOM * P_CHANNELS + 1),
  localparam int WW = $clog2(P_WINDOW + 1),
  localparam int IW = $clog2(P_IDLE + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_win_tick,
  input  logic [P_CHANNELS-1:0] i_spike_in,
  output logic                  o_active,
  output logic                  o_timeout,
  output logic [CW-1:0]         o_spike_cnt,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_NOM   = CW'(P_SPIKE_NOM);
  localparam logic [WW-1:0] WIN_LAST  = WW'(P_WINDOW - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(P_IDLE - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WW-1:0] win_cnt, win_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic          active_q, timeout_q, timeout_n;
  logic [CW-1:0] inc, sum;
  logic          trigger;

`ifdef SPIKE_POPCOUNT_EN
  // Each set spike line is one event, so k simultaneous lines add k.
  always_comb begin
    inc = '0;
    for (int i = 0; i < P_CHANNELS; i++) begin
      inc = inc + CW'(i_spike_in[i]);
    end
  end
`else
  // Any activity in a cycle counts as a single event.
  always_comb begin
    inc = CW'(|i_spike_in);
  end
`endif

  // The count is held below P_SPIKE_NOM, so the sum always fits in CW bits.
  always_comb begin
    sum     = cnt + inc;
    trigger = (inc != '0) && (sum >= CNT_NOM);
  end

  // Compute the next state, counters and timeout pulse. Clear has top priority.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    win_n     = win_cnt;
    idle_n    = idle_cnt;
    timeout_n = 1'b0;
    if (i_clear) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      win_n   = '0;
      idle_n  = '0;
    end else begin
      // Accumulation and watchdog. Excess events on a trigger are dropped.
      if (trigger) begin
        cnt_n   = '0;
        idle_n  = '0;
        win_n   = '0;
        state_n = ST_ACTIVE;
      end else if (inc != '0) begin
        cnt_n  = sum;
        idle_n = '0;
        if (state == ST_IDLE) state_n = ST_ACCUM;
      end else if (cnt != '0) begin
        if (idle_cnt == IDLE_LAST) begin
          cnt_n     = '0;
          idle_n    = '0;
          timeout_n = 1'b1;
          if (state == ST_ACCUM) state_n = ST_IDLE;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
      end else begin
        idle_n = '0;
      end
      // Window time base. A trigger in the same cycle wins over the window end.
      if ((state == ST_ACTIVE) && !trigger && i_win_tick) begin
        if (win_cnt == WIN_LAST) begin
          win_n   = '0;
          state_n = ST_IDLE;
        end else begin
          win_n = win_cnt + 1'b1;
        end
      end
    end
  end

  // Register the state and counters. The outputs are registered here as well.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      win_cnt   <= '0;
      idle_cnt  <= '0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      win_cnt   <= win_n;
      idle_cnt  <= idle_n;
      active_q  <= (state_n == ST_ACTIVE);
      timeout_q <= timeout_n;
    end
  end

  assign o_active    = active_q;
  assign o_timeout   = timeout_q;
  assign o_spike_cnt = cnt;
  assign o_state     = state;

endmodule
